// File: rtl/soc_test_ctrl_pkg.sv
// Shared types for the SoC test controller: FSM state encoding and the default end-of-test address.
package soc_test_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0FFC;

endpackage

// File: rtl/soc_test_ctrl_trace_fifo.sv
// Circular trace buffer: registered write, combinational head read, never stalls.
// When full, a push overwrites the oldest entry and sets the sticky ovf flag unless a pop retires it first.
module soc_test_ctrl_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             pop_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    full   = (cnt_q == CNT_FULL);
    pop_ok = pop && (cnt_q != '0);

    if (push) tail_d = tail_q + 1'b1;

    // A full push always retires the oldest entry; it only counts as lost if nobody popped it.
    if (push && full) begin
      head_d = head_q + 1'b1;
      if (!pop) ovf_d = 1'b1;
    end else begin
      if (pop_ok) head_d = head_q + 1'b1;
      if (push && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop_ok) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_dat;
  end

  assign head_dat = mem_q[head_q];
  assign empty    = (cnt_q == '0);
  assign ovf      = ovf_q;

endmodule

// File: rtl/soc_test_ctrl.sv
// SoC test controller: stretched core reset, RUN-time event counters, tohost/timeout verdict, store trace.
// Verdict registers one edge after the deciding cycle; inputs are observed only, never back-pressured.
module soc_test_ctrl
  import soc_test_ctrl_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
  parameter int                TRACE_DEPTH    = 8,
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              core_reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              stall,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  input  logic              trace_rd_en,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic              trace_empty,
  output logic              trace_ovf
);

  localparam int                HOLD_W       = $clog2(RESET_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] PASS_VALUE   = DATA_W'(1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [DATA_W-1:0]  fail_code_q, fail_code_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic               wr_done;
  logic               rd_done;
  logic               trace_push;
  logic [ADDR_W+DATA_W-1:0] trace_head;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    fail_code_d  = fail_code_q;
    cycle_cnt_d  = cycle_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    trace_push   = 1'b0;

    // A cycle with both strobes is a store; the load strobe is ignored.
    wr_done = mem_write && !stall;
    rd_done = mem_read && !mem_write && !stall;

    case (state_q)
      ST_HOLD: begin
        core_reset_d = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (wr_done) begin
          wr_cnt_d   = wr_cnt_q + 1'b1;
          trace_push = 1'b1;
        end
        if (rd_done) rd_cnt_d = rd_cnt_q + 1'b1;

        // The tohost store outranks a timeout falling on the same cycle.
        if (wr_done && (mem_addr == TOHOST_ADDR)) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          timeout_d   = 1'b0;
          pass_d      = (mem_wdata == PASS_VALUE);
          fail_code_d = (mem_wdata == PASS_VALUE) ? '0 : (mem_wdata >> 1);
        end else if (cycle_cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      ST_DONE: begin
        core_reset_d = 1'b0;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_code_q  <= '0;
      cycle_cnt_q  <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      fail_code_q  <= fail_code_d;
      cycle_cnt_q  <= cycle_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  soc_test_ctrl_trace_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .push     (trace_push),
    .push_dat ({mem_addr, mem_wdata}),
    .pop      (trace_rd_en),
    .head_dat (trace_head),
    .empty    (trace_empty),
    .ovf      (trace_ovf)
  );

  assign trace_addr = trace_head[ADDR_W+DATA_W-1:DATA_W];
  assign trace_data = trace_head[DATA_W-1:0];

  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign fail_code  = fail_code_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_soc_test_ctrl.sv
// Directed bench for soc_test_ctrl with a short timeout so every scenario fits in one run window.
module tb_soc_test_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              core_reset;
  logic              mem_write = 1'b0;
  logic              mem_read = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              done, pass, timeout;
  logic [DATA_W-1:0] fail_code;
  logic [CNT_W-1:0]  cycle_cnt, rd_cnt, wr_cnt;
  logic              trace_rd_en = 1'b0;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic              trace_empty, trace_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  soc_test_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .RESET_CYCLES   (4),
    .TIMEOUT_CYCLES (20),
    .TOHOST_ADDR    (TOHOST),
    .TRACE_DEPTH    (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_reset  (core_reset),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .fail_code   (fail_code),
    .cycle_cnt   (cycle_cnt),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .trace_rd_en (trace_rd_en),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_empty (trace_empty),
    .trace_ovf   (trace_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    stall       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    trace_rd_en = 1'b0;
  endtask

  // Reset for one edge, then wait out the four hold cycles so the controller is in RUN.
  task automatic start_run();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    // Reset values and reset stretch
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_trace_empty", trace_empty, 1);
    chk("rst_trace_ovf", trace_ovf, 0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hold_core_reset_%0d", i), core_reset, 1);
    end
    tick();
    chk("hold_release", core_reset, 0);
    chk("run_cycle_start", cycle_cnt, 0);

    // Stalled store completes only when stall drops
    mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hAA; stall = 1'b1;
    repeat (3) tick();
    chk("stall_wr_cnt", wr_cnt, 0);
    chk("stall_trace_empty", trace_empty, 1);
    stall = 1'b0;
    tick();
    mem_write = 1'b0;
    chk("store_wr_cnt", wr_cnt, 1);
    chk("store_trace_addr", trace_addr, 32'h10);
    chk("store_trace_data", trace_data, 32'hAA);
    mem_read = 1'b1; stall = 1'b1;
    tick();
    chk("stall_rd_cnt", rd_cnt, 0);
    stall = 1'b0;
    tick();
    chk("load_rd_cnt", rd_cnt, 1);
    mem_write = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h55;
    tick();
    mem_write = 1'b0; mem_read = 1'b0;
    chk("both_wr_cnt", wr_cnt, 2);
    chk("both_rd_cnt", rd_cnt, 1);
    chk("run_cycle_cnt", cycle_cnt, 7);

    // Passing tohost store, then frozen counters
    store(TOHOST, 32'd1);
    chk("pass_done", done, 1);
    chk("pass_pass", pass, 1);
    chk("pass_fail_code", fail_code, 0);
    chk("pass_timeout", timeout, 0);
    chk("pass_wr_cnt", wr_cnt, 3);
    chk("pass_cycle_cnt", cycle_cnt, 8);
    mem_write = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h9;
    repeat (2) tick();
    mem_write = 1'b0;
    chk("frozen_wr_cnt", wr_cnt, 3);
    chk("frozen_cycle_cnt", cycle_cnt, 8);
    chk("frozen_core_reset", core_reset, 0);
    chk("frozen_done", done, 1);

    // Trace readout in DONE
    chk("pop0_addr", trace_addr, 32'h10);
    trace_rd_en = 1'b1;
    tick();
    chk("pop1_addr", trace_addr, 32'h20);
    chk("pop1_data", trace_data, 32'h55);
    tick();
    chk("pop2_addr", trace_addr, TOHOST);
    chk("pop2_data", trace_data, 32'd1);
    tick();
    trace_rd_en = 1'b0;
    chk("pop_empty", trace_empty, 1);

    // Failing tohost store
    start_run();
    chk("fail_pre_done", done, 0);
    store(TOHOST, 32'd7);
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_code", fail_code, 3);
    chk("fail_timeout", timeout, 0);

    // Timeout after 20 RUN cycles
    start_run();
    repeat (19) tick();
    chk("to_not_yet", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_cycle_cnt", cycle_cnt, 20);
    repeat (3) tick();
    chk("to_cycle_frozen", cycle_cnt, 20);

    // Tohost store on the timeout cycle wins
    start_run();
    repeat (19) tick();
    store(TOHOST, 32'd1);
    chk("race_pass", pass, 1);
    chk("race_timeout", timeout, 0);
    chk("race_cycle_cnt", cycle_cnt, 20);

    // Ten stores into eight entries
    start_run();
    for (int i = 1; i <= 10; i++) begin
      store(32'(i * 4), 32'(i));
      if (i == 8) chk("ovf_before_wrap", trace_ovf, 0);
    end
    chk("ovf_set", trace_ovf, 1);
    chk("ovf_wr_cnt", wr_cnt, 10);
    trace_rd_en = 1'b1;
    for (int k = 3; k <= 10; k++) begin
      chk($sformatf("ovf_addr_%0d", k), trace_addr, 32'(k * 4));
      chk($sformatf("ovf_data_%0d", k), trace_data, 32'(k));
      tick();
    end
    chk("ovf_drained", trace_empty, 1);
    tick();
    trace_rd_en = 1'b0;
    chk("pop_when_empty", trace_empty, 1);
    chk("ovf_sticky", trace_ovf, 1);

    // Push and pop together while full: no overflow
    start_run();
    for (int i = 1; i <= 8; i++) store(32'(i * 4), 32'(i));
    trace_rd_en = 1'b1;
    store(32'd36, 32'd9);
    trace_rd_en = 1'b0;
    chk("pp_full_ovf", trace_ovf, 0);
    chk("pp_full_head", trace_data, 2);
    trace_rd_en = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("pp_data_%0d", k), trace_data, 32'(k));
      tick();
    end
    trace_rd_en = 1'b0;
    chk("pp_drained", trace_empty, 1);

    // Reset in the middle of RUN
    start_run();
    store(32'h40, 32'h1234);
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_core_reset", core_reset, 1);
    chk("mid_wr_cnt", wr_cnt, 0);
    chk("mid_rd_cnt", rd_cnt, 0);
    chk("mid_cycle_cnt", cycle_cnt, 0);
    chk("mid_trace_empty", trace_empty, 1);
    chk("mid_done", done, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_hold", core_reset, 1);
    tick();
    chk("mid_release", core_reset, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
